// File: rtl/d_branch_ctrl_pkg.sv
// Shared encodings and constants for the decode-stage branch controller.
// Branch kinds, FSM states and the counter width live here so NPC/hazard code can agree on them.
package d_branch_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  // Reserved code 7 behaves exactly like BR_NONE.
  function automatic logic is_branch_type(input logic [2:0] t);
    return (t != BR_NONE) && (t != BR_RSVD);
  endfunction

  // Only the two-operand compares depend on rt.
  function automatic logic needs_rt(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE);
  endfunction

endpackage

// File: rtl/d_br_cmp.sv
// Combinational D-stage operand comparator: equality tests and signed tests of rs against zero.
module d_br_cmp
  import d_branch_ctrl_pkg::*;
(
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [2:0]  br_type,
  output logic        taken
);

  logic signed [31:0] rs_s;
  logic               eq;
  logic               neg;
  logic               zero;

  always_comb begin
    rs_s  = rd1;
    eq    = (rd1 == rd2);
    neg   = (rs_s < 0);
    zero  = (rd1 == 32'd0);
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLEZ: taken = neg || zero;
      BR_BGTZ: taken = !neg && !zero;
      BR_BLTZ: taken = neg;
      BR_BGEZ: taken = !neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_ctrl.sv
// Decode-stage branch resolution controller: waits for final forwarded operands, registers the
// compare outcome and target, pulses a one-cycle redirect to fetch, and counts branches/taken.
module d_branch_ctrl
  import d_branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [2:0]       D_br_type,
  input  logic [31:0]      D_RD1,
  input  logic [31:0]      D_RD2,
  input  logic             D_rs_ready,
  input  logic             D_rt_ready,
  input  logic [31:0]      D_pc,
  input  logic [15:0]      D_imm16,
  input  logic             D_flush,
  input  logic             cnt_clr,
  output logic             D_stall,
  output logic             D_redirect,
  output logic [31:0]      D_target,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e      state;
  logic        taken_p0;
  logic        is_br_p0;
  logic        ready_p0;
  logic [31:0] target_p0;
  logic        inc;

  d_br_cmp u_cmp (
    .rd1     (D_RD1),
    .rd2     (D_RD2),
    .br_type (D_br_type),
    .taken   (taken_p0)
  );

  always_comb begin
    is_br_p0  = D_valid && is_branch_type(D_br_type);
    ready_p0  = D_rs_ready && (D_rt_ready || !needs_rt(D_br_type));
    target_p0 = D_pc + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    inc       = (state == RESOLVE) && !D_flush;
    // Gated by reset so the stall also drops the instant reset is applied.
    D_stall   = !reset && !D_flush &&
                (((state == IDLE) && is_br_p0) || (state == WAIT));
  end

  // Capture boundary: D-stage compare/target -> registered redirect stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      D_redirect <= 1'b0;
      D_target   <= 32'd0;
      br_cnt     <= '0;
      taken_cnt  <= '0;
    end else begin
      D_redirect <= 1'b0;
      if (D_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, WAIT: begin
            if (!is_br_p0) begin
              state <= IDLE;
            end else if (ready_p0) begin
              D_redirect <= taken_p0;
              D_target   <= target_p0;
              state      <= RESOLVE;
            end else begin
              state <= WAIT;
            end
          end
          RESOLVE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (cnt_clr) begin
        br_cnt    <= '0;
        taken_cnt <= '0;
      end else if (inc) begin
        br_cnt <= br_cnt + CNT_W'(1);
        if (D_redirect)
          taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Directed bench for d_branch_ctrl: each task drives one scenario and checks hand-computed values.
module tb_d_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_valid;
  logic [2:0]  D_br_type;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic        D_rs_ready;
  logic        D_rt_ready;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic        D_flush;
  logic        cnt_clr;
  logic        D_stall;
  logic        D_redirect;
  logic [31:0] D_target;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_tk = 0;

  localparam logic [2:0]  TV_TYPE [8] = '{3'd3, 3'd3, 3'd5, 3'd5, 3'd6, 3'd6, 3'd1, 3'd2};
  localparam logic [31:0] TV_RD1  [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0,
                                          32'h0, 32'h8000_0000, 32'h5, 32'h5};
  localparam logic        TV_TK   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  d_branch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_valid    (D_valid),
    .D_br_type  (D_br_type),
    .D_RD1      (D_RD1),
    .D_RD2      (D_RD2),
    .D_rs_ready (D_rs_ready),
    .D_rt_ready (D_rt_ready),
    .D_pc       (D_pc),
    .D_imm16    (D_imm16),
    .D_flush    (D_flush),
    .cnt_clr    (cnt_clr),
    .D_stall    (D_stall),
    .D_redirect (D_redirect),
    .D_target   (D_target),
    .br_cnt     (br_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic rsr, input logic rtr, input logic [31:0] pc,
                        input logic [15:0] imm);
    D_valid    = 1'b1;
    D_br_type  = t;
    D_RD1      = a;
    D_RD2      = b;
    D_rs_ready = rsr;
    D_rt_ready = rtr;
    D_pc       = pc;
    D_imm16    = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    D_valid = 1'b0; D_br_type = 3'd0; D_RD1 = 0; D_RD2 = 0;
    D_rs_ready = 1'b0; D_rt_ready = 1'b0; D_pc = 0; D_imm16 = 0;
    D_flush = 1'b0; cnt_clr = 1'b0;
    #3;
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b exp 0", D_stall); end
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL reset_redirect got %0b exp 0", D_redirect); end
    vectors++; if (D_target !== 32'h0) begin miscompares++; $display("FAIL reset_target got %h exp 0", D_target); end
    vectors++; if (br_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_br_cnt got %h exp 0", br_cnt); end
    vectors++; if (taken_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_taken_cnt got %h exp 0", taken_cnt); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken();
    set_br(3'd1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h3000, 16'h0004);
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL beq_detect_stall got %0b exp 1", D_stall); end
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL beq_detect_redirect got %0b exp 0", D_redirect); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL beq_redirect got %0b exp 1", D_redirect); end
    vectors++; if (D_target !== 32'h3014) begin miscompares++; $display("FAIL beq_target got %h exp 00003014", D_target); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL beq_resolve_stall got %0b exp 0", D_stall); end
    tick();
    exp_br = exp_br + 1; exp_tk = exp_tk + 1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL beq_pulse_end got %0b exp 0", D_redirect); end
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL beq_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL beq_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_bne_not_taken();
    set_br(3'd2, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1, 1'b1, 32'h3100, 16'h0020);
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL bne_stall got %0b exp 1", D_stall); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL bne_redirect got %0b exp 0", D_redirect); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL bne_resolve_stall got %0b exp 0", D_stall); end
    tick();
    exp_br = exp_br + 1;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL bne_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL bne_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_bgtz();
    // rt not ready and RD2 garbage: neither may matter for a zero test
    set_br(3'd4, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h4000, 16'hFFFF);
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL bgtz_neg_stall got %0b exp 1", D_stall); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL bgtz_neg_redirect got %0b exp 0", D_redirect); end
    tick();
    exp_br = exp_br + 1;
    set_br(3'd4, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h4000, 16'hFFFF);
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL bgtz_pos_stall got %0b exp 1", D_stall); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL bgtz_pos_redirect got %0b exp 1", D_redirect); end
    vectors++; if (D_target !== 32'h4000) begin miscompares++; $display("FAIL bgtz_pos_target got %h exp 00004000", D_target); end
    tick();
    exp_br = exp_br + 1; exp_tk = exp_tk + 1;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL bgtz_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL bgtz_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_cond_table();
    for (int i = 0; i < 8; i++) begin
      set_br(TV_TYPE[i], TV_RD1[i], 32'h6, 1'b1, (i >= 6), 32'h0100, 16'h0010);
      #1;
      vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL cond%0d_stall got %0b exp 1", i, D_stall); end
      tick();
      D_valid = 1'b0;
      #1;
      vectors++; if (D_redirect !== TV_TK[i]) begin miscompares++; $display("FAIL cond%0d_redirect got %0b exp %0b", i, D_redirect, TV_TK[i]); end
      if (TV_TK[i]) begin
        vectors++; if (D_target !== 32'h0144) begin miscompares++; $display("FAIL cond%0d_target got %h exp 00000144", i, D_target); end
      end
      tick();
      exp_br = exp_br + 1;
      if (TV_TK[i]) exp_tk = exp_tk + 1;
    end
    // Reserved code is not a branch
    set_br(3'd7, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0200, 16'h0001);
    #1;
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL rsvd_stall got %0b exp 0", D_stall); end
    tick();
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL rsvd_redirect got %0b exp 0", D_redirect); end
    D_valid = 1'b0;
    tick();
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL cond_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL cond_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_wait();
    set_br(3'd1, 32'h77, 32'h77, 1'b1, 1'b0, 32'h2000, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL wait%0d_stall got %0b exp 1", i, D_stall); end
      vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL wait%0d_redirect got %0b exp 0", i, D_redirect); end
      tick();
    end
    D_rt_ready = 1'b1;
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL wait_ready_stall got %0b exp 1", D_stall); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL wait_redirect got %0b exp 1", D_redirect); end
    vectors++; if (D_target !== 32'h2404) begin miscompares++; $display("FAIL wait_target got %h exp 00002404", D_target); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL wait_resolve_stall got %0b exp 0", D_stall); end
    tick();
    exp_br = exp_br + 1; exp_tk = exp_tk + 1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL wait_pulse_end got %0b exp 0", D_redirect); end
  endtask

  task automatic test_flush_wait();
    set_br(3'd1, 32'h9, 32'h9, 1'b1, 1'b0, 32'h6000, 16'h0004);
    tick();
    #1;
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL flush_pre_stall got %0b exp 1", D_stall); end
    D_flush = 1'b1;
    D_rt_ready = 1'b1;
    #1;
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %0b exp 0", D_stall); end
    tick();
    D_flush = 1'b0;
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL flush_redirect got %0b exp 0", D_redirect); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle_stall got %0b exp 0", D_stall); end
    tick();
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL flush_redirect2 got %0b exp 0", D_redirect); end
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL flush_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL flush_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_back_to_back();
    set_br(3'd1, 32'h1, 32'h1, 1'b1, 1'b1, 32'h5000, 16'h0008);
    tick();
    // Delay slot holds a second branch
    set_br(3'd2, 32'h1, 32'h2, 1'b1, 1'b1, 32'h5004, 16'h0010);
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL b2b_first_redirect got %0b exp 1", D_redirect); end
    vectors++; if (D_target !== 32'h5024) begin miscompares++; $display("FAIL b2b_first_target got %h exp 00005024", D_target); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_resolve_stall got %0b exp 0", D_stall); end
    tick();
    vectors++; if (D_stall !== 1'b1) begin miscompares++; $display("FAIL b2b_second_stall got %0b exp 1", D_stall); end
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_redirect got %0b exp 0", D_redirect); end
    tick();
    D_valid = 1'b0;
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL b2b_second_redirect got %0b exp 1", D_redirect); end
    vectors++; if (D_target !== 32'h5048) begin miscompares++; $display("FAIL b2b_second_target got %h exp 00005048", D_target); end
    tick();
    exp_br = exp_br + 2; exp_tk = exp_tk + 2;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL b2b_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL b2b_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_wrap();
    force dut.br_cnt = 32'hFFFF_FFFF;
    force dut.taken_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    release dut.taken_cnt;
    set_br(3'd1, 32'h3, 32'h3, 1'b1, 1'b1, 32'h7000, 16'h0000);
    tick();
    D_valid = 1'b0;
    tick();
    exp_br = 32'h0; exp_tk = 32'h0;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL wrap_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL wrap_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_clr_resolve();
    set_br(3'd6, 32'h0, 32'h0, 1'b1, 1'b0, 32'h7100, 16'h0001);
    tick();
    D_valid = 1'b0;
    tick();
    exp_br = exp_br + 1; exp_tk = exp_tk + 1;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL clr_pre_br_cnt got %h exp %h", br_cnt, exp_br); end
    set_br(3'd1, 32'h4, 32'h4, 1'b1, 1'b1, 32'h7200, 16'h0001);
    tick();
    D_valid = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_br = 32'h0; exp_tk = 32'h0;
    vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("FAIL clr_br_cnt got %h exp %h", br_cnt, exp_br); end
    vectors++; if (taken_cnt !== exp_tk) begin miscompares++; $display("FAIL clr_taken_cnt got %h exp %h", taken_cnt, exp_tk); end
  endtask

  task automatic test_async_reset();
    set_br(3'd1, 32'h8, 32'h8, 1'b1, 1'b1, 32'h7300, 16'h0002);
    tick();
    #1;
    vectors++; if (D_redirect !== 1'b1) begin miscompares++; $display("FAIL areset_pre_redirect got %0b exp 1", D_redirect); end
    #1;
    reset = 1'b1;
    #1;
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL areset_redirect got %0b exp 0", D_redirect); end
    vectors++; if (D_target !== 32'h0) begin miscompares++; $display("FAIL areset_target got %h exp 0", D_target); end
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL areset_stall got %0b exp 0", D_stall); end
    #1;
    D_valid = 1'b0;
    reset = 1'b0;
    tick();
    vectors++; if (D_redirect !== 1'b0) begin miscompares++; $display("FAIL areset_post_redirect got %0b exp 0", D_redirect); end
    vectors++; if (br_cnt !== 32'h0) begin miscompares++; $display("FAIL areset_br_cnt got %h exp 0", br_cnt); end
    // Reset mid-WAIT must also leave the FSM idle
    set_br(3'd1, 32'h8, 32'h8, 1'b1, 1'b0, 32'h7400, 16'h0002);
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL areset_wait_stall got %0b exp 0", D_stall); end
    D_valid = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    vectors++; if (D_stall !== 1'b0) begin miscompares++; $display("FAIL areset_wait_idle got %0b exp 0", D_stall); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_bgtz();
    test_cond_table();
    test_wait();
    test_flush_wait();
    test_back_to_back();
    test_wrap();
    test_clr_resolve();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
